// File: rtl/backprop_sequencer.sv
// -----------------------------------------------------------------------------
// backprop_sequencer
//
// Produces the per-cycle control word for the backprop register chain. A pass
// walks the layers from last to first and the step slots of each layer, one
// word per unstalled cycle. After the last word it waits for the register
// pipeline to drain and then pulses done.
//
// Ports:
//   clk               - single clock, rising edge
//   rst_n             - synchronous active-low reset
//   start             - request a pass (sampled only while idle)
//   num_layers        - layers to process, latched when start is accepted
//   stall             - downstream hold; while running, emits enable=0 words
//   backprop_controll - registered word {enable, last, layer_idx, step_idx}
//   busy              - pass in progress (accept+1 through the cycle before done)
//   done              - one-cycle completion pulse
// -----------------------------------------------------------------------------
module backprop_sequencer #(
    parameter int unsigned steps_per_layer        = 3,
    parameter int unsigned pipe_depth             = 4,
    parameter int unsigned backprop_controll_size = 66
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [31:0]                       num_layers,
    input  logic                              stall,
    output logic [backprop_controll_size-1:0] backprop_controll,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] last_step  = 32'(steps_per_layer - 1);
    localparam logic [31:0] last_drain = 32'(pipe_depth - 1);

    state_t                            state_q, state_d;
    logic [31:0]                       layer_cnt_q, layer_cnt_d;
    logic [31:0]                       step_cnt_q, step_cnt_d;
    logic [31:0]                       drain_cnt_q, drain_cnt_d;
    logic [backprop_controll_size-1:0] word_q, word_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic                              is_last;

    // NOTE: every signal written here gets a default before the case statement,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        layer_cnt_d = layer_cnt_q;
        step_cnt_d  = step_cnt_q;
        drain_cnt_d = drain_cnt_q;
        word_d      = '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        is_last     = (layer_cnt_q == 32'd0) && (step_cnt_q == last_step);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_layers != 32'd0) begin
                        layer_cnt_d = num_layers - 32'd1;
                        step_cnt_d  = 32'd0;
                        drain_cnt_d = 32'd0;
                        busy_d      = 1'b1;
                        state_d     = RUN;
                    end else begin
                        // Empty pass: complete immediately without going busy.
                        done_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (stall) begin
                    // Position is still visible, but enable=0 so nothing consumes it.
                    word_d = {1'b0, 1'b0, layer_cnt_q, step_cnt_q};
                end else begin
                    word_d = {1'b1, is_last, layer_cnt_q, step_cnt_q};
                    if (is_last) begin
                        layer_cnt_d = 32'd0;
                        step_cnt_d  = 32'd0;
                        drain_cnt_d = 32'd0;
                        state_d     = DRAIN;
                    end else if (step_cnt_q == last_step) begin
                        step_cnt_d  = 32'd0;
                        layer_cnt_d = layer_cnt_q - 32'd1;
                    end else begin
                        step_cnt_d  = step_cnt_q + 32'd1;
                    end
                end
            end

            DRAIN: begin
                // The last word needs pipe_depth edges to reach the final consumer.
                if (drain_cnt_q == last_drain) begin
                    drain_cnt_d = 32'd0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: reset is sampled on the clock edge only, and all state updates use
    // non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            layer_cnt_q <= '0;
            step_cnt_q  <= '0;
            drain_cnt_q <= '0;
            word_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_cnt_q <= layer_cnt_d;
            step_cnt_q  <= step_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            word_q      <= word_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign backprop_controll = word_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: doc/backprop_sequencer.md
Name: backprop_sequencer

Overview:
- Generates the per-cycle `backprop_controll` word consumed by the backprop register stages (the `diff_backprop_reg` chain).
- Walks layers from last to first, and the step slots within each layer, one word per unstalled cycle.
- After the last word it waits for the register pipeline to drain, then signals completion.
- Sits between the training top-level controller (start/done) and the head of the backprop pipeline.

Parameters:
- steps_per_layer, 3, words issued per layer (matches the per-layer vector size); must be >= 1.
- pipe_depth, 4, number of delay stages between this block and the last consumer; drain length in cycles; must be >= 1.
- backprop_controll_size, 66, control word width; fixed at 1+1+32+32.

Ports:
- clk  input  1  Single clock; all state updates on rising edge.
- rst_n  input  1  Reset, synchronous, active-low.
- start  input  1  Request a backprop pass. Sampled only in IDLE.
- num_layers  input  32  Layers to process. Latched when start is accepted.
- stall  input  1  Downstream hold. While high in RUN: no advance, enable=0 is emitted.
- backprop_controll  output  66  Registered control word, layout below.
- busy  output  1  High from the cycle after start is accepted through the cycle before done.
- done  output  1  One-cycle completion pulse.

Behaviour:
- Word layout:
  - [65] enable
  - [64] last
  - [63:32] layer_idx, unsigned
  - [31:0] step_idx, unsigned
- Reset: at a rising edge with rst_n=0, regardless of state, go to IDLE.
  - Cleared: backprop_controll=0, busy=0, done=0, all counters 0.
  - Applies mid-RUN or mid-DRAIN; no further enable=1 words are issued.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Output word is 0.
  - start=1 and num_layers!=0: latch layer_cnt=num_layers-1, step_cnt=0, busy<=1, go RUN.
  - start=1 and num_layers==0: done<=1 for one cycle, stay IDLE, busy stays 0.
  - start is accepted in IDLE even in the same cycle that done is high.
- RUN, stall=0, each edge:
  - Word <= {1, last, layer_cnt, step_cnt}, where last = (layer_cnt==0 && step_cnt==steps_per_layer-1).
  - If step_cnt==steps_per_layer-1: step_cnt<=0 and layer_cnt<=layer_cnt-1. Otherwise step_cnt<=step_cnt+1.
  - When the last word is loaded: drain_cnt<=0, go DRAIN.
- RUN, stall=1, each edge: word <= {0, 0, layer_cnt, step_cnt}; counters hold.
- DRAIN:
  - Word <= 0 each edge; stall is ignored; drain_cnt increments.
  - When drain_cnt==pipe_depth-1: done<=1, busy<=0, go IDLE.
  - Net effect: done rises pipe_depth edges after the edge that loaded the last word.
- done: high for exactly one cycle per accepted start.
- start: ignored while busy=1.
- num_layers: changes after acceptance have no effect.
- Latency: start high at edge E0 (accepted) puts the first word (enable=1) on the output from E1, provided stall=0 at E1.
- Word count: unstalled, the pass issues num_layers*steps_per_layer consecutive enable=1 words.
- Counter widths: counters are 32-bit; wrap cannot occur within a legal pass.

Test Plan:
- Basic pass (defaults, num_layers=2, stall=0, start pulsed at E0):
  - Words E1..E6 = (1,0,1,0), (1,0,1,1), (1,0,1,2), (1,0,0,0), (1,0,0,1), (1,1,0,2), where fields are (enable, last, layer_idx, step_idx).
  - Word 0 from E7.
  - done=1 for exactly the cycle after E10; busy=1 from E1 until E10.
- Stall mid-pass: same setup, stall=1 during edges E3–E4.
  - E3, E4 emit enable=0, layer=1, step=2.
  - The remaining words are shifted by 2 cycles; done at E12; total enable=1 words = 6.
- Zero layers: num_layers=0, start at E0 → done=1 after E0 for one cycle; busy stays 0; no enable=1 word is ever issued.
- Start while busy: second start pulse at E3 of the basic pass is ignored → the sequence is identical to the basic pass and only one done pulse occurs.
- Reset mid-pass: rst_n=0 at E4 → word=0, busy=0, done=0 from E4; start at E6 runs a complete fresh pass from layer_idx=1, step_idx=0.
- Back-to-back: start held high continuously → a new pass is accepted on the edge where done is high; its first word appears one edge later.
